// File: rtl/axi_fanout_resp_buf_pkg.sv
// Shared AXI node definitions: branch-select encoding and a clog2 helper
// used when sizing pointers and occupancy counters.
package axi_fanout_resp_buf_pkg;

    typedef enum logic {
        BR0 = 1'b0,
        BR1 = 1'b1
    } br_sel_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_resp_fifo.sv
// Per-branch response buffer: circular storage with read/write pointers and
// an occupancy counter; head entry is presented while non-empty.
module axi_resp_fifo
    import axi_fanout_resp_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic                     full_o,
    output logic                     req_o,
    input  logic                     gnt_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [clog2(DEPTH):0]    cnt_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push;
    logic             pop;

    // Push is qualified against full here too so occupancy can never overshoot.
    assign full_o  = (cnt_q == FULL_CNT);
    assign req_o   = (cnt_q != '0);
    assign rdata_o = mem_q[rptr_q];
    assign cnt_o   = cnt_q;
    assign push    = push_i && !full_o;
    assign pop     = req_o && gnt_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by the counter alone.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axi_fanout_resp_buf.sv
// Response fan-out: routes each slave response by one ID bit into one of two
// independent branch buffers; grant depends only on the selected buffer state.
module axi_fanout_resp_buf
    import axi_fanout_resp_buf_pkg::*;
#(
    parameter int AUX_WIDTH = 32,
    parameter int ID_WIDTH  = 16,
    parameter int SEL_BIT   = ID_WIDTH - 1,
    parameter int DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_req_i,
    input  logic [ID_WIDTH-1:0]      data_ID_i,
    input  logic [AUX_WIDTH-1:0]     data_AUX_i,
    output logic                     data_gnt_o,
    output logic                     data_req0_o,
    output logic [ID_WIDTH-1:0]      data_ID0_o,
    output logic [AUX_WIDTH-1:0]     data_AUX0_o,
    input  logic                     data_gnt0_i,
    output logic                     data_req1_o,
    output logic [ID_WIDTH-1:0]      data_ID1_o,
    output logic [AUX_WIDTH-1:0]     data_AUX1_o,
    input  logic                     data_gnt1_i,
    output logic [clog2(DEPTH):0]    cnt0_o,
    output logic [clog2(DEPTH):0]    cnt1_o
);

    localparam int WIDTH = ID_WIDTH + AUX_WIDTH;

    br_sel_e          sel;
    logic             full0, full1;
    logic             push0, push1;
    logic             xfer;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata0, rdata1;

    assign sel   = br_sel_e'(data_ID_i[SEL_BIT]);
    assign wdata = {data_ID_i, data_AUX_i};

    // Grant looks only at the selected buffer's fill state; during reset the
    // buffers are being cleared, so grant reports the empty state.
    assign data_gnt_o = rst || ((sel == BR0) ? !full0 : !full1);
    assign xfer       = data_req_i && data_gnt_o && !rst;
    assign push0      = xfer && (sel == BR0);
    assign push1      = xfer && (sel == BR1);

    axi_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push0),
        .wdata_i (wdata),
        .full_o  (full0),
        .req_o   (data_req0_o),
        .gnt_i   (data_gnt0_i),
        .rdata_o (rdata0),
        .cnt_o   (cnt0_o)
    );

    axi_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push1),
        .wdata_i (wdata),
        .full_o  (full1),
        .req_o   (data_req1_o),
        .gnt_i   (data_gnt1_i),
        .rdata_o (rdata1),
        .cnt_o   (cnt1_o)
    );

    assign {data_ID0_o, data_AUX0_o} = rdata0;
    assign {data_ID1_o, data_AUX1_o} = rdata1;

endmodule

// File: tb/tb_axi_fanout_resp_buf.sv
// Directed bench for the two-branch response fan-out buffer with default
// parameters (ID 16 bits, payload 32 bits, select bit 15, depth 2).
module tb_axi_fanout_resp_buf;

    logic        clk;
    logic        rst;
    logic        data_req_i;
    logic [15:0] data_ID_i;
    logic [31:0] data_AUX_i;
    logic        data_gnt_o;
    logic        data_req0_o;
    logic [15:0] data_ID0_o;
    logic [31:0] data_AUX0_o;
    logic        data_gnt0_i;
    logic        data_req1_o;
    logic [15:0] data_ID1_o;
    logic [31:0] data_AUX1_o;
    logic        data_gnt1_i;
    logic [1:0]  cnt0_o;
    logic [1:0]  cnt1_o;

    int total;
    int bad;

    axi_fanout_resp_buf dut (
        .clk         (clk),
        .rst         (rst),
        .data_req_i  (data_req_i),
        .data_ID_i   (data_ID_i),
        .data_AUX_i  (data_AUX_i),
        .data_gnt_o  (data_gnt_o),
        .data_req0_o (data_req0_o),
        .data_ID0_o  (data_ID0_o),
        .data_AUX0_o (data_AUX0_o),
        .data_gnt0_i (data_gnt0_i),
        .data_req1_o (data_req1_o),
        .data_ID1_o  (data_ID1_o),
        .data_AUX1_o (data_AUX1_o),
        .data_gnt1_i (data_gnt1_i),
        .cnt0_o      (cnt0_o),
        .cnt1_o      (cnt1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [15:0] id, input logic [31:0] aux);
        data_req_i = req;
        data_ID_i  = id;
        data_AUX_i = aux;
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        data_req_i  = 1'b0;
        data_ID_i   = '0;
        data_AUX_i  = '0;
        data_gnt0_i = 1'b1;
        data_gnt1_i = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Idle after reset
        chk("rst_req0", 64'(data_req0_o), 64'd0);
        chk("rst_req1", 64'(data_req1_o), 64'd0);
        chk("rst_cnt0", 64'(cnt0_o), 64'd0);
        chk("rst_cnt1", 64'(cnt1_o), 64'd0);
        chk("rst_gnt", 64'(data_gnt_o), 64'd1);

        // Back-to-back routing to both branches
        drive(1'b1, 16'h0005, 32'hA5A5A5A5);
        chk("route_gnt_a", 64'(data_gnt_o), 64'd1);
        step();
        chk("route_req0", 64'(data_req0_o), 64'd1);
        chk("route_id0", 64'(data_ID0_o), 64'h0005);
        chk("route_aux0", 64'(data_AUX0_o), 64'hA5A5A5A5);
        chk("route_req1_idle", 64'(data_req1_o), 64'd0);
        drive(1'b1, 16'h8003, 32'h5A5A5A5A);
        chk("route_gnt_b", 64'(data_gnt_o), 64'd1);
        step();
        chk("route_req0_pop", 64'(data_req0_o), 64'd0);
        chk("route_req1", 64'(data_req1_o), 64'd1);
        chk("route_id1", 64'(data_ID1_o), 64'h8003);
        chk("route_aux1", 64'(data_AUX1_o), 64'h5A5A5A5A);
        drive(1'b0, 16'h0000, 32'h0);
        step();
        chk("route_req1_pop", 64'(data_req1_o), 64'd0);

        // Back-pressure on branch 0 until full, then drain in order
        data_gnt0_i = 1'b0;
        drive(1'b1, 16'h0001, 32'h11);
        chk("bp_gnt1", 64'(data_gnt_o), 64'd1);
        step();
        chk("bp_cnt_1", 64'(cnt0_o), 64'd1);
        drive(1'b1, 16'h0002, 32'h22);
        chk("bp_gnt2", 64'(data_gnt_o), 64'd1);
        step();
        drive(1'b1, 16'h0003, 32'h33);
        chk("bp_gnt3_full", 64'(data_gnt_o), 64'd0);
        chk("bp_cnt_full", 64'(cnt0_o), 64'd2);
        chk("bp_head1", 64'(data_ID0_o), 64'h0001);
        // Popping in the same cycle must not open the grant while full
        data_gnt0_i = 1'b1;
        #1;
        chk("bp_gnt_full_pop", 64'(data_gnt_o), 64'd0);
        step();
        chk("bp_cnt_after_pop", 64'(cnt0_o), 64'd1);
        chk("bp_head2", 64'(data_ID0_o), 64'h0002);
        chk("bp_gnt3_now", 64'(data_gnt_o), 64'd1);
        // ID 3 pushed while ID 2 pops: occupancy holds at 1
        step();
        chk("pp_cnt_hold", 64'(cnt0_o), 64'd1);
        chk("pp_head3", 64'(data_ID0_o), 64'h0003);
        chk("pp_aux3", 64'(data_AUX0_o), 64'h33);
        drive(1'b0, 16'h0000, 32'h0);
        step();
        chk("bp_drained", 64'(cnt0_o), 64'd0);
        chk("bp_req0_low", 64'(data_req0_o), 64'd0);

        // Branch 0 full and stalled does not block branch 1
        data_gnt0_i = 1'b0;
        drive(1'b1, 16'h0010, 32'h100);
        step();
        drive(1'b1, 16'h0011, 32'h101);
        step();
        drive(1'b1, 16'h8001, 32'hBEEF);
        chk("ind_gnt_b1", 64'(data_gnt_o), 64'd1);
        step();
        chk("ind_req1", 64'(data_req1_o), 64'd1);
        chk("ind_id1", 64'(data_ID1_o), 64'h8001);
        chk("ind_cnt0", 64'(cnt0_o), 64'd2);
        data_gnt1_i = 1'b0;
        drive(1'b1, 16'h0012, 32'h102);
        chk("ind_gnt_b0_full", 64'(data_gnt_o), 64'd0);
        drive(1'b0, 16'h0000, 32'h0);
        step();
        chk("pre_rst_cnt0", 64'(cnt0_o), 64'd2);
        chk("pre_rst_cnt1", 64'(cnt1_o), 64'd1);

        // Reset mid-operation discards everything; inputs ignored
        rst = 1'b1;
        data_gnt0_i = 1'b1;
        data_gnt1_i = 1'b1;
        drive(1'b1, 16'h0005, 32'h55);
        chk("rst_gnt_during", 64'(data_gnt_o), 64'd1);
        step();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 32'h0);
        chk("mid_rst_cnt0", 64'(cnt0_o), 64'd0);
        chk("mid_rst_cnt1", 64'(cnt1_o), 64'd0);
        chk("mid_rst_req0", 64'(data_req0_o), 64'd0);
        chk("mid_rst_req1", 64'(data_req1_o), 64'd0);
        step();
        chk("post_rst_cnt0", 64'(cnt0_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_fanout_resp_buf.md
AXI_FANOUT_RESP_BUF -- requirements
Module: axi_fanout_resp_buf

Interface
REQ-001 Parameter AUX_WIDTH, default 32, SHALL set the width of the response payload (data/resp/last/user bundle).
REQ-002 Parameter ID_WIDTH, default 16, SHALL set the width of the response ID.
REQ-003 Parameter SEL_BIT, default ID_WIDTH-1, SHALL be the ID bit index that selects the destination branch.
REQ-004 Parameter DEPTH, default 2, SHALL be the entries per branch buffer, a power of two and at least 2.
REQ-005 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-007 Port data_req_i  input  1  SHALL flag a valid response from the slave side.
REQ-008 Port data_ID_i  input  ID_WIDTH  SHALL carry the response ID.
REQ-009 Port data_AUX_i  input  AUX_WIDTH  SHALL carry the response payload.
REQ-010 Port data_gnt_o  output  1  SHALL accept the response; a transfer occurs when data_req_i and data_gnt_o are both 1.
REQ-011 Ports data_req0_o/data_req1_o  output  1 each  SHALL flag a valid response toward master branch 0/1.
REQ-012 Ports data_ID0_o/data_ID1_o  output  ID_WIDTH each  SHALL carry the buffered ID, unmodified.
REQ-013 Ports data_AUX0_o/data_AUX1_o  output  AUX_WIDTH each  SHALL carry the buffered payload.
REQ-014 Ports data_gnt0_i/data_gnt1_i  input  1 each  SHALL flag acceptance by branch 0/1.
REQ-015 Ports cnt0_o/cnt1_o  output  clog2(DEPTH)+1 each  SHALL give the current occupancy of each branch buffer.

Function
REQ-016 Routing SHALL use data_ID_i[SEL_BIT]: 0 selects branch 0 and 1 selects branch 1.
REQ-017 data_gnt_o SHALL equal "selected branch buffer not full", computed combinationally.
REQ-018 data_gnt_o SHALL NOT depend on data_req_i or on any data_gntX_i in the same cycle, so there is no combinational path from gnt inputs to gnt output.
REQ-019 On an input transfer, ID and AUX SHALL be written at the selected buffer's write pointer, and that pointer SHALL advance modulo DEPTH.
REQ-020 data_reqX_o SHALL be 1 exactly when buffer X is non-empty.
REQ-021 data_IDX_o and data_AUXX_o SHALL present the head entry of buffer X.
REQ-022 On data_reqX_o and data_gntX_i both 1, buffer X SHALL pop and its read pointer SHALL advance modulo DEPTH.
REQ-023 Latency from input transfer to data_reqX_o rising SHALL be exactly 1 cycle.
REQ-024 Sustained throughput per branch SHALL be 1 response per cycle when not back-pressured.
REQ-025 Simultaneous push and pop on the same non-full buffer SHALL leave occupancy unchanged and preserve order.
REQ-026 When a buffer is full, data_gnt_o SHALL be 0 for responses to that branch even if that branch pops in the same cycle.
REQ-027 Each branch SHALL preserve FIFO order.
REQ-028 The two branches SHALL be independent: a stall on one branch SHALL NOT block responses to the other.
REQ-029 Output payloads while data_reqX_o is 0 SHALL be don't-care; the bench SHALL NOT check them.
REQ-030 Occupancy SHALL never exceed DEPTH and never underflow.

Reset
REQ-031 While rst=1 at a clock edge, all pointers and counts SHALL clear to 0, so data_req0_o=data_req1_o=0 and cnt0_o=cnt1_o=0 from the next cycle.
REQ-032 Reset mid-operation SHALL discard all buffered responses with no output transfer in the reset cycle.
REQ-033 Storage arrays SHALL NOT need reset.
REQ-034 During reset, data_gnt_o SHALL reflect the cleared (empty) state, that is 1, and inputs SHALL be ignored.

Structure
REQ-035 A shared AXI node package SHALL hold a clog2 constant function and the branch-select enum (BR0=0, BR1=1).
REQ-036 The per-branch buffer SHALL be one sub-module, axi_resp_fifo (parameters DEPTH and width ID_WIDTH+AUX_WIDTH), instantiated twice.
REQ-037 The top level SHALL contain only routing and grant logic.

Verification
REQ-038 Reset release with idle inputs -> data_req0_o=data_req1_o=0, cnt=0, data_gnt_o=1.
REQ-039 ID=16'h0005 with AUX=32'hA5A5A5A5, then ID=16'h8003 with AUX=32'h5A5A5A5A on consecutive cycles, gnt inputs held 1 -> branch 0 presents 0005/A5A5A5A5 on cycle 1 and branch 1 presents 8003/5A5A5A5A on cycle 2.
REQ-040 data_gnt0_i=0 and three branch-0 responses (IDs 1, 2, 3) -> first two accepted; data_gnt_o=0 on the third with cnt0_o=2; after data_gnt0_i=1, outputs arrive in order 1, 2, 3.
REQ-041 Branch 0 full and stalled, then branch-1 response ID=16'h8001 -> accepted immediately, data_req1_o=1 one cycle later.
REQ-042 Branch 0 holding 1 entry, simultaneous push and pop on branch 0 -> cnt0_o stays 1 and order is preserved.
REQ-043 rst asserted with cnt0_o=2 and cnt1_o=1 -> next cycle all counts are 0 and no data_reqX_o is asserted.
